// File: rtl/arb_pkg.sv
// Shared types, defaults and width helper for the round-robin lock arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_NUM_PORTS_DEF = 4;
  localparam int ARB_TIMEOUT_DEF   = 16;

  // Index width for n ports, never narrower than one bit.
  function automatic int arb_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin search: the first set request bit at or after the
// pointer, wrapping modulo N. Returns it one-hot and as an index.
module rr_prio_pick
  import arb_pkg::*;
#(
  parameter int N  = ARB_NUM_PORTS_DEF,
  parameter int IW = arb_idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;
  logic           found;

  // Rotating a doubled copy puts the pointer's port at bit 0.
  assign dbl   = {req_i, req_i} >> ptr_i;
  assign rot   = dbl[N-1:0];
  assign any_o = |dbl;

  // Lowest set bit of the rotated vector, mapped back to a real port index.
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    sum    = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_i} + (IW+1)'(i);
        if (sum >= (IW+1)'(N)) begin
          sum = sum - (IW+1)'(N);
        end
        idx_o  = sum[IW-1:0];
        pick_o = N'(1) << sum;
      end
    end
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Registered round-robin arbiter that locks a grant until done, request drop
// or (when ARB_GNT_TIMEOUT_EN is defined) a watchdog timeout.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS      = ARB_NUM_PORTS_DEF,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEF,
  localparam int IW            = arb_idx_w(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 done_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 gnt_valid_o,
  output logic [IW-1:0]        gnt_id_o,
  output logic                 timeout_o
);

  if (NUM_PORTS < 1 || NUM_PORTS > 32 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("rr_lock_arbiter: parameter out of legal range");
  end

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]        gntId_q, gntId_d;
  logic                 gntValid_q, gntValid_d;

  logic [IW-1:0]        incPtr, arbPtr, pickIdx;
  logic [NUM_PORTS-1:0] pick;
  logic                 pickAny, dropRel, toRel, releaseEv, newGrant;

  assign incPtr  = (gntId_q == IW'(NUM_PORTS - 1)) ? '0 : gntId_q + IW'(1);
  assign dropRel = ~|(req_i & gnt_q);
  assign arbPtr  = (state_q == BUSY) ? incPtr : ptr_q;

  rr_prio_pick #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_pick (
    .req_i  (req_i),
    .ptr_i  (arbPtr),
    .pick_o (pick),
    .idx_o  (pickIdx),
    .any_o  (pickAny)
  );

  // Arbitrate from IDLE or on a release; otherwise the grant is frozen.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    gntId_d    = gntId_q;
    newGrant   = 1'b0;
    releaseEv  = (state_q == BUSY) && (done_i || dropRel || toRel);
    if (state_q == IDLE || releaseEv) begin
      if (releaseEv) begin
        ptr_d = incPtr;
      end
      if (pickAny) begin
        gnt_d    = pick;
        gntId_d  = pickIdx;
        state_d  = BUSY;
        newGrant = 1'b1;
      end else begin
        gnt_d   = '0;
        gntId_d = '0;
        state_d = IDLE;
      end
    end
    gntValid_d = |gnt_d;
  end

  // Grant, pointer and state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      gntId_q    <= '0;
      gntValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      gntId_q    <= gntId_d;
      gntValid_q <= gntValid_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gntId_q;
  assign gnt_valid_o = gntValid_q;

`ifdef ARB_GNT_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  assign toRel = (state_q == BUSY) && (cnt_q == TO_LAST);

  // Count held cycles; a fresh grant or going idle restarts at zero.
  always_comb begin
    cnt_d = '0;
    if (state_d == BUSY && !newGrant) begin
      cnt_d = cnt_q + 16'd1;
    end
    timeout_d = toRel && !done_i && !dropRel;
  end

  // Watchdog counter and timeout pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign toRel     = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_rr_lock_arbiter;

  localparam int N  = 4;
  localparam int TO = 4;
`ifdef ARB_GNT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         reset_n;
  logic [N-1:0] req_i;
  logic         done_i;
  logic [N-1:0] gnt_o;
  logic         gnt_valid_o;
  logic [1:0]   gnt_id_o;
  logic         timeout_o;

  int testsRun;
  int testsFailed;

  // Model state: granted port (-1 = none), pointer, cycles held, timeout pulse.
  int mGnt;
  int mPtr;
  int mHeld;
  bit mTo;

  rr_lock_arbiter #(
    .NUM_PORTS      (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req_i),
    .done_i      (done_i),
    .gnt_o       (gnt_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_id_o    (gnt_id_o),
    .timeout_o   (timeout_o)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int searchFrom(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mGnt  = -1;
    mPtr  = 0;
    mHeld = 0;
    mTo   = 1'b0;
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic modelEdge();
    bit rel;
    mTo = 1'b0;
    if (mGnt < 0) begin
      mGnt  = searchFrom(req_i, mPtr);
      mHeld = 1;
    end else begin
      rel = 1'b0;
      if (done_i || !req_i[mGnt]) begin
        rel = 1'b1;
      end else if (TO_EN && mHeld >= TO) begin
        rel = 1'b1;
        mTo = 1'b1;
      end
      if (rel) begin
        mPtr  = (mGnt + 1) % N;
        mGnt  = searchFrom(req_i, mPtr);
        mHeld = 1;
      end else begin
        mHeld++;
      end
    end
  endtask

  task automatic compareAll(input string tag);
    logic [31:0] expGnt;
    expGnt = (mGnt >= 0) ? (32'd1 << mGnt) : 32'd0;
    checkOutput({tag, "_gnt"}, 32'(gnt_o), expGnt);
    checkOutput({tag, "_id"}, 32'(gnt_id_o), (mGnt >= 0) ? 32'(mGnt) : 32'd0);
    checkOutput({tag, "_valid"}, 32'(gnt_valid_o), 32'(mGnt >= 0));
    checkOutput({tag, "_timeout"}, 32'(timeout_o), 32'(mTo));
  endtask

  // Drive inputs at the falling edge, clock once, compare at the next falling edge.
  task automatic applyStimulus(input string tag, input logic [N-1:0] r, input logic d);
    req_i  = r;
    done_i = d;
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    compareAll(tag);
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    logic [N-1:0] r;
    logic [N-1:0] rotSeq [5];
    testsRun    = 0;
    testsFailed = 0;
    reset_n     = 1'b0;
    req_i       = '0;
    done_i      = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    compareAll("reset");
    reset_n = 1'b1;

    // Reset mid-grant drops the grant without a clock edge.
    applyStimulus("rst_pre", 4'b0100, 1'b0);
    checkOutput("rst_pre_gnt_const", 32'(gnt_o), 32'h4);
    #2 reset_n = 1'b0;
    #1;
    modelReset();
    compareAll("rst_async");
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus("rst_post", 4'b0100, 1'b0);
    checkOutput("rst_post_gnt_const", 32'(gnt_o), 32'h4);
    applyStimulus("rst_idle", 4'b0000, 1'b0);

    // Rotation with all ports requesting and done every cycle.
    rotSeq[0] = 4'b0001; rotSeq[1] = 4'b0010; rotSeq[2] = 4'b0100;
    rotSeq[3] = 4'b1000; rotSeq[4] = 4'b0001;
    reset_n = 1'b0;
    #1;
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus("rot", 4'b1111, 1'b0);
    checkOutput("rot_seq0", 32'(gnt_o), 32'(rotSeq[0]));
    for (int i = 1; i < 5; i++) begin
      applyStimulus("rot", 4'b1111, 1'b1);
      checkOutput("rot_seq", 32'(gnt_o), 32'(rotSeq[i]));
    end
    applyStimulus("rot_end", 4'b0000, 1'b0);

    // Hold: port 1 keeps the grant while others request.
    applyStimulus("hold_start", 4'b0010, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("hold", 4'b1011, 1'b0);
      if (!TO_EN) checkOutput("hold_id_const", 32'(gnt_id_o), 32'd1);
    end
    applyStimulus("hold_end", 4'b0000, 1'b0);

    // Abort: port 3 drops its request, port 0 takes over.
    applyStimulus("abort_start", 4'b1000, 1'b0);
    applyStimulus("abort", 4'b0001, 1'b0);
    checkOutput("abort_gnt_const", 32'(gnt_o), 32'h1);
    applyStimulus("abort_end", 4'b0000, 1'b0);

    // Lone requester is re-granted on every release.
    for (int i = 0; i < 8; i++) begin
      applyStimulus("lone", 4'b0010, 1'(i % 2));
      checkOutput("lone_gnt_const", 32'(gnt_o), 32'h2);
    end
    applyStimulus("lone_end", 4'b0000, 1'b0);

    // Watchdog: held port 2 without done, then done on the fourth cycle.
    for (int i = 0; i < 6; i++) applyStimulus("to_hold", 4'b0100, 1'b0);
    applyStimulus("to_gap", 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("to_done", 4'b0100, 1'(i == 3));
    checkOutput("to_done_nopulse", 32'(timeout_o), 32'd0);
    applyStimulus("to_end", 4'b0000, 1'b0);

    // Random traffic with sticky requests so grants are held a while.
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      applyStimulus("rand", r, 1'($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 99) == 0) begin
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        compareAll("rand_rst");
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
